// File: rtl/ram_multiplex_unit_if.sv
// rtl/ram_multiplex_unit_if.sv - bit-select request/result bundle
// Signals:
//   data          source word, bit 0 is LSB
//   regs          unsigned index of the bit to forward
//   is_valid      qualifies data/regs for the current cycle
//   ram_bit       registered selected bit (0 when not qualified)
//   ram_bit_valid registered: ram_bit holds a qualified in-range selection
//   sel_err       registered: qualified request with regs >= DATA_W
// Modports: master drives the request and observes the result; slave is the unit.
interface ram_multiplex_unit_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 4
);
  logic [DATA_W-1:0] data;
  logic [SEL_W-1:0]  regs;
  logic              is_valid;
  logic              ram_bit;
  logic              ram_bit_valid;
  logic              sel_err;

  modport master (
    output data, regs, is_valid,
    input  ram_bit, ram_bit_valid, sel_err
  );

  modport slave (
    input  data, regs, is_valid,
    output ram_bit, ram_bit_valid, sel_err
  );
endinterface

// File: rtl/ram_multiplex_unit.sv
// rtl/ram_multiplex_unit.sv - registered single-bit selector with range check
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset, clears all three outputs
//   bus    ram_multiplex_unit_if.slave: data/regs/is_valid in,
//          ram_bit/ram_bit_valid/sel_err out, one cycle latency
module ram_multiplex_unit #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ram_multiplex_unit_if.slave  bus
);

  // One extra bit so DATA_W == 2**SEL_W is representable.
  localparam logic [SEL_W:0] DATA_W_L = (SEL_W + 1)'(DATA_W);

  logic in_range;
  logic sel_bit;
  logic ram_bit_q;
  logic ram_bit_valid_q;
  logic sel_err_q;

  assign in_range = ({1'b0, bus.regs} < DATA_W_L);

  // Compare-and-pick instead of data[regs]: never indexes past DATA_W-1,
  // and unselected bits (even X/Z) cannot reach sel_bit.
  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (bus.regs == SEL_W'(i)) begin
        sel_bit = bus.data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_bit_q       <= 1'b0;
      ram_bit_valid_q <= 1'b0;
      sel_err_q       <= 1'b0;
    end else begin
      ram_bit_q       <= bus.is_valid & in_range & sel_bit;
      ram_bit_valid_q <= bus.is_valid & in_range;
      sel_err_q       <= bus.is_valid & ~in_range;
    end
  end

  assign bus.ram_bit       = ram_bit_q;
  assign bus.ram_bit_valid = ram_bit_valid_q;
  assign bus.sel_err       = sel_err_q;

endmodule

// File: tb/tb_ram_multiplex_unit.sv
// tb/tb_ram_multiplex_unit.sv - directed self-checking bench for ram_multiplex_unit
module tb_ram_multiplex_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ram_multiplex_unit_if #(.DATA_W(16), .SEL_W(4)) bus16 ();
  ram_multiplex_unit_if #(.DATA_W(12), .SEL_W(4)) bus12 ();

  ram_multiplex_unit #(.DATA_W(16), .SEL_W(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  ram_multiplex_unit #(.DATA_W(12), .SEL_W(4)) dut12 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed/expected packed as {ram_bit, ram_bit_valid, sel_err}.
  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] obs16();
    return {bus16.ram_bit, bus16.ram_bit_valid, bus16.sel_err};
  endfunction

  function automatic logic [2:0] obs12();
    return {bus12.ram_bit, bus12.ram_bit_valid, bus12.sel_err};
  endfunction

  // Bits 0..15 of 16'h8E8E, worked out by hand.
  logic exp_bits [16] = '{0,1,1,1,0,0,0,1,0,1,1,1,0,0,0,1};

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus16.data = 16'hFFFF; bus16.regs = 4'd1; bus16.is_valid = 1'b1;
    bus12.data = 12'hFFF;  bus12.regs = 4'd1; bus12.is_valid = 1'b1;

    // Reset wins over a qualified request.
    step();
    step();
    check("reset16", obs16(), 3'b000);
    check("reset12", obs12(), 3'b000);
    rst_n = 1'b1;
    bus12.is_valid = 1'b0;

    // Gate-off sweep with wrap.
    bus16.data = 16'h8E8E;
    bus16.is_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus16.regs = 4'(i % 16);
      step();
      check($sformatf("gate_off_%0d", i), obs16(), 3'b000);
    end

    // Enabled sweep.
    bus16.is_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus16.regs = 4'(i);
      step();
      check($sformatf("sweep_%0d", i), obs16(), {exp_bits[i], 2'b10});
    end

    // Index wrap 15 -> 0 -> 1.
    bus16.regs = 4'd15; step(); check("wrap_15", obs16(), 3'b110);
    bus16.regs = 4'd0;  step(); check("wrap_0",  obs16(), 3'b010);
    bus16.regs = 4'd1;  step(); check("wrap_1",  obs16(), 3'b110);

    // Reset mid-stream, then recovery one cycle after release.
    bus16.regs = 4'd1;
    rst_n = 1'b0; step(); check("mid_reset", obs16(), 3'b000);
    rst_n = 1'b1; step(); check("post_reset", obs16(), 3'b110);

    // Out-of-range handling at DATA_W=12; bit 11 set, bit 0 clear.
    bus12.data = 12'h800;
    bus12.is_valid = 1'b1;
    bus12.regs = 4'd13; step(); check("oor_13", obs12(), 3'b001);
    bus12.regs = 4'd11; step(); check("top_11", obs12(), 3'b110);
    bus12.regs = 4'd12; step(); check("oor_12", obs12(), 3'b001);
    bus12.regs = 4'd15; step(); check("oor_15", obs12(), 3'b001);
    bus12.regs = 4'd0;  step(); check("low_0",  obs12(), 3'b010);
    bus12.is_valid = 1'b0;
    bus12.regs = 4'd14; step(); check("oor_idle", obs12(), 3'b000);

    // Toggle qualify.
    bus16.data = 16'h0008;
    bus16.regs = 4'd3;
    for (int i = 0; i < 6; i++) begin
      bus16.is_valid = ((i % 2) == 0);
      step();
      check($sformatf("toggle_%0d", i), obs16(), ((i % 2) == 0) ? 3'b110 : 3'b000);
    end

    // Unknown values on unselected bits.
    bus16.data = 16'hxxxx;
    bus16.data[5] = 1'b1;
    bus16.regs = 4'd5;
    bus16.is_valid = 1'b1;
    step(); check("x_unsel", obs16(), 3'b110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_multiplex_unit.md
RAM_MULTIPLEX_UNIT -- requirements
Module: ram_multiplex_unit

Interface
REQ-001 Parameter DATA_W, default 16, width of the data word being bit-selected; SHALL be >= 2.
REQ-002 Parameter SEL_W, default 4, width of the bit-select index; SHALL satisfy 2**SEL_W >= DATA_W.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 Port data, input, DATA_W bits: source word; bit 0 is LSB.
REQ-006 Port regs, input, SEL_W bits: index of the data bit to forward.
REQ-007 Port is_valid, input, 1 bit: qualifies data/regs for the current cycle.
REQ-008 Port ram_bit, output, 1 bit, registered: selected data bit, or 0 when not qualified.
REQ-009 Port ram_bit_valid, output, 1 bit, registered: high when ram_bit carries a qualified in-range selection.
REQ-010 Port sel_err, output, 1 bit, registered: high when is_valid was high with regs >= DATA_W.

Function
REQ-011 Each rising clk with rst_n high SHALL sample data, regs and is_valid and update all outputs; latency is exactly 1 cycle from input to output.
REQ-012 If is_valid=1 and regs < DATA_W: ram_bit <= data[regs], ram_bit_valid <= 1, sel_err <= 0.
REQ-013 If is_valid=0: ram_bit <= 0, ram_bit_valid <= 0, sel_err <= 0, regardless of data and regs.
REQ-014 If is_valid=1 and regs >= DATA_W (only possible when DATA_W < 2**SEL_W): ram_bit <= 0, ram_bit_valid <= 0, sel_err <= 1; data is never indexed out of range.
REQ-015 No handshake or backpressure; a new selection is accepted every cycle, and outputs reflect only the previous cycle's inputs.
REQ-016 The regs index SHALL be treated as unsigned; wrap of an external counter driving regs (e.g. 15 -> 0 at SEL_W=4) needs no special handling.
REQ-017 X/Z on data bits not selected SHALL NOT affect outputs.
REQ-018 The block has no internal state besides the three output registers; no FSM.

Reset
REQ-019 While rst_n=0 at a rising clk: ram_bit <= 0, ram_bit_valid <= 0, sel_err <= 0; inputs are ignored.
REQ-020 Reset takes precedence over is_valid in the same cycle; the first sample after reset release is taken at the first rising clk with rst_n=1.
REQ-021 Output values before the first rising clk are not defined; the bench SHALL apply reset for at least one cycle.

Verification
REQ-022 Gate-off sweep: data=16'h8E8E, is_valid=0, regs stepped 0..15 then wrapping to 0..3 -> ram_bit=0 and ram_bit_valid=0 every cycle.
REQ-023 Enabled sweep: data=16'h8E8E, is_valid=1, regs 0..15 one per cycle -> ram_bit one cycle later = 0,1,1,1,0,0,0,1,0,1,1,1,0,0,0,1; ram_bit_valid=1 throughout.
REQ-024 Wrap: is_valid=1, regs 15 -> 0 -> 1 with data=16'h8E8E -> ram_bit 1,0,1; no sel_err.
REQ-025 Reset mid-stream: is_valid=1, regs=1 (selected bit=1), assert rst_n=0 for one cycle -> all outputs 0 in the next cycle; after release, ram_bit=1 one cycle later.
REQ-026 Out-of-range (DATA_W=12, SEL_W=4): is_valid=1, regs=13 -> ram_bit=0, ram_bit_valid=0, sel_err=1; regs=11 with data[11]=1 -> ram_bit=1, sel_err=0.
REQ-027 Toggle qualify: alternate is_valid 1/0 each cycle with regs=3, data=16'h0008 -> ram_bit alternates 1/0 with a 1-cycle delay.
